tdp_ram_be: RTL and testbench
=============================

# tdp_ram_be

Parametrised true dual-port synchronous RAM with per-byte write enables and configurable read latency. It succeeds the single-mode `dp_ram`. It adds:
- explicit port enables with read-valid outputs;
- selectable read-during-write behaviour;
- deterministic per-byte resolution of same-address write collisions, plus a collision flag;
- a reset-triggered clear sequencer that zeroes the array in hardware.

It is the shared storage primitive for buffers and register files that need two independent read/write agents.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- RD_LATENCY, 1, request-to-data latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-port read-during-write behaviour:
  - 0: read-first (old word returned).
  - 1: write-first (merged new word returned).
- WINNER_B, 1, same-lane write collision priority:
  - 1: port B wins.
  - 0: port A wins.
- INIT_ON_RESET, 1, selects whether the array is zero-filled after reset:
  - 1: clear sequencer zero-fills the array after reset.
  - 0: no clear.

Ports (X = A or B, one set per port):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the clear sequencer runs.
- enX  in  1  port X access request.
- wrX  in  1  port X access type: 1 = write, 0 = read; qualified by enX.
- beX  in  NB  port X byte-lane write enables; used only when wrX=1.
- addrX  in  ADDR_WIDTH  port X word address.
- dataX_in  in  DATA_WIDTH  port X write data.
- dataX_out  out  DATA_WIDTH  port X read data.
- validX  out  1  one-cycle pulse qualifying dataX_out.
- collision  out  1  pulse: both ports hit the same address in one cycle and at least one wrote.

## Operation
- Control FSM states: CLEAR, RUN.
  - rst_n low: FSM goes to CLEAR (INIT_ON_RESET=1) or RUN (INIT_ON_RESET=0); clear counter goes to 0.
  - CLEAR: writes 0 to address clr_cnt each cycle, then increments clr_cnt. After writing DEPTH-1, moves to RUN. clr_cnt never wraps past DEPTH-1.
  - RUN: terminal state until the next reset.
- Requests with enX=1 while in CLEAR are dropped: no array write, no validX.
- Port X read (enX=1, wrX=0): validX pulses after RD_LATENCY cycles with mem[addrX].
- Port X write (enX=1, wrX=1): lanes with beX[i]=1 take dataX_in lane i; other lanes are unchanged.
  - validX still pulses.
  - dataX_out is the old word (RDW_MODE=0) or the merged new word (RDW_MODE=1).
  - beX all-zero: no array change, but validX still pulses.
- enX=0: no access; dataX_out holds its last value; validX=0.
- Cross-port, same address, one port writes: the reading port always receives the old word.
- Both ports write the same address:
  - lanes enabled by only one port take that port's data;
  - lanes enabled by both take the winner's data (WINNER_B).
  - Never X.
- collision = enA & enB & (addrA==addrB) & (wrA|wrB), sampled in RUN. It is pipelined to align with validX.
- Elaboration error if DATA_WIDTH % BYTE_WIDTH != 0 or RD_LATENCY is not 1 or 2.

## Timing
- Reset values: dataA_out=dataB_out=0, validA=validB=0, collision=0, init_busy=INIT_ON_RESET.
- Reset asserted mid-operation: all outputs return to reset values immediately.
  - In-flight read results are discarded.
  - Array contents are not reset asynchronously; INIT_ON_RESET=1 restarts the clear from address 0.
- Clear duration: exactly DEPTH rising edges after rst_n deasserts. init_busy falls at the edge that writes DEPTH-1; the first accepted request is on the next edge.
- Request sampled at edge N:
  - array updates at edge N;
  - data/valid/collision visible after edge N+RD_LATENCY.
- RD_LATENCY=2 adds one output register stage.
- Back-to-back requests on every cycle are supported on both ports (full throughput); valid pulses are contiguous.
- A write at edge N followed by a read of the same address at edge N+1 (either port) returns the new data.

## Test plan
- Reset, INIT_ON_RESET=1, DEPTH=16: init_busy high for 16 edges after rst_n rises. A read request during clear gets no validA. Reading all 16 addresses afterwards returns 0x00.
- A writes 0xA1 to 0x1; B reads 0x1 on the next cycle -> validB with 0xA1 after RD_LATENCY (check both 1 and 2).
- DATA_WIDTH=16, BYTE_WIDTH=8: mem[0x3]=0x1234; A writes 0xABCD with beA=2'b10 -> subsequent read returns 0xAB34.
- Same-cycle writes to 0x6, A=0xF6F6 beA=11, B=0x1717 beB=01, WINNER_B=1 -> mem[0x6]=0xF617, collision pulses. With WINNER_B=0 -> 0xF6F6.
- A writes 0x55 to 0x2 (old 0x22) while B reads 0x2 in the same cycle -> dataB_out=0x22. dataA_out=0x22 (RDW_MODE=0) or 0x55 (RDW_MODE=1). collision=1.
- Assert rst_n mid-stream with reads pending -> validA/validB drop at once, no stale pulse after release, and clear restarts from address 0.

Source files
------------

// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write behaviour, deterministic same-address write
// collision resolution and a hardware clear sequencer that runs after reset.
module tdp_ram_be #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int BYTE_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = 0,
    parameter int WINNER_B      = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             init_busy,
    input  logic                             enA,
    input  logic                             wrA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] beA,
    input  logic [ADDR_WIDTH-1:0]            addrA,
    input  logic [DATA_WIDTH-1:0]            dataA_in,
    output logic [DATA_WIDTH-1:0]            dataA_out,
    output logic                             validA,
    input  logic                             enB,
    input  logic                             wrB,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] beB,
    input  logic [ADDR_WIDTH-1:0]            addrB,
    input  logic [DATA_WIDTH-1:0]            dataB_in,
    output logic [DATA_WIDTH-1:0]            dataB_out,
    output logic                             validB,
    output logic                             collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("tdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("tdp_ram_be: RD_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  run;
    logic                  acc_a, acc_b;
    logic                  wr_en_a, wr_en_b;
    logic                  same_addr;
    logic [NB-1:0]         lane_a, lane_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;

    logic [DATA_WIDTH-1:0] rd1_a, rd1_b;
    logic                  v1_a, v1_b, col1;

    assign run       = (state == ST_RUN);
    assign init_busy = (state == ST_CLEAR);
    assign acc_a     = run & enA;
    assign acc_b     = run & enB;
    assign wr_en_a   = acc_a & wrA;
    assign wr_en_b   = acc_b & wrB;
    assign same_addr = (addrA == addrB);
    assign lane_a    = {NB{wr_en_a}} & beA;
    assign lane_b    = {NB{wr_en_b}} & beB;

    // Control FSM: zero-fill sweep after reset, then terminal RUN state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == ADDR_WIDTH'(DEPTH - 1))
                state <= ST_RUN;
            else
                clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Merge both ports' lanes into the words they address. When both ports
    // hit the same word, both merged words carry the fully resolved value, so
    // the two array writes below agree and their order does not matter.
    always_comb begin
        old_a = mem[addrA];
        old_b = mem[addrB];
        new_a = old_a;
        new_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (same_addr && lane_b[i] && (!lane_a[i] || WINNER_B != 0))
                new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dataB_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (lane_a[i])
                new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dataA_in[i*BYTE_WIDTH +: BYTE_WIDTH];

            if (same_addr && lane_a[i] && (!lane_b[i] || WINNER_B == 0))
                new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dataA_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (lane_b[i])
                new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dataB_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Array update: clear sweep has exclusive access, otherwise port writes.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_en_a) mem[addrA] <= new_a;
            if (wr_en_b) mem[addrB] <= new_b;
        end
    end

    // First read stage: capture read data, valid pulses and collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_a <= '0;
            rd1_b <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            col1  <= 1'b0;
        end else begin
            v1_a <= acc_a;
            v1_b <= acc_b;
            col1 <= acc_a & acc_b & same_addr & (wrA | wrB);
            if (acc_a)
                rd1_a <= (wrA && RDW_MODE != 0) ? new_a : old_a;
            if (acc_b)
                rd1_b <= (wrB && RDW_MODE != 0) ? new_b : old_b;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rd2_a, rd2_b;
        logic                  v2_a, v2_b, col2;

        // Optional output register stage; data only advances with a valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_a <= '0;
                rd2_b <= '0;
                v2_a  <= 1'b0;
                v2_b  <= 1'b0;
                col2  <= 1'b0;
            end else begin
                v2_a <= v1_a;
                v2_b <= v1_b;
                col2 <= col1;
                if (v1_a) rd2_a <= rd1_a;
                if (v1_b) rd2_b <= rd1_b;
            end
        end

        assign dataA_out = rd2_a;
        assign dataB_out = rd2_b;
        assign validA    = v2_a;
        assign validB    = v2_b;
        assign collision = col2;
    end else begin : g_lat1
        assign dataA_out = rd1_a;
        assign dataB_out = rd1_b;
        assign validA    = v1_a;
        assign validB    = v1_b;
        assign collision = col1;
    end

endmodule

// File: tb/tb_tdp_ram_be.sv
// Testbench for tdp_ram_be: two instances driven by the same stimulus,
// u0 = latency 1 / read-first / B wins, u1 = latency 2 / write-first / A wins.
module tb_tdp_ram_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, wr_a, en_b, wr_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;

    logic        busy0, va0, vb0, col0;
    logic [15:0] da0, db0;
    logic        busy1, va1, vb1, col1;
    logic [15:0] da1, db1;

    tdp_ram_be #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_LATENCY(1), .RDW_MODE(0), .WINNER_B(1), .INIT_ON_RESET(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .enA(en_a), .wrA(wr_a), .beA(be_a), .addrA(addr_a), .dataA_in(din_a),
        .dataA_out(da0), .validA(va0),
        .enB(en_b), .wrB(wr_b), .beB(be_b), .addrB(addr_b), .dataB_in(din_b),
        .dataB_out(db0), .validB(vb0),
        .collision(col0)
    );

    tdp_ram_be #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_LATENCY(2), .RDW_MODE(1), .WINNER_B(0), .INIT_ON_RESET(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .enA(en_a), .wrA(wr_a), .beA(be_a), .addrA(addr_a), .dataA_in(din_a),
        .dataA_out(da1), .validA(va1),
        .enB(en_b), .wrB(wr_b), .beB(be_b), .addrB(addr_b), .dataB_in(din_b),
        .dataB_out(db1), .validB(vb1),
        .collision(col1)
    );

    typedef struct {
        logic        en_a, wr_a;
        logic [1:0]  be_a;
        logic [3:0]  addr_a;
        logic [15:0] din_a;
        logic        en_b, wr_b;
        logic [1:0]  be_b;
        logic [3:0]  addr_b;
        logic [15:0] din_b;
        logic        va;
        logic [15:0] da0, da1;
        logic        vb;
        logic [15:0] db0, db1;
        logic        col;
    } vec_t;

    typedef struct {
        int          due;
        logic        va;
        logic [15:0] da;
        logic        vb;
        logic [15:0] db;
        logic        col;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nchk  = 0;
    int   nfail = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_due();
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            exp_t e = q0.pop_front();
            chk("u0 validA", va0, e.va);
            chk("u0 dataA", da0, e.da);
            chk("u0 validB", vb0, e.vb);
            chk("u0 dataB", db0, e.db);
            chk("u0 collision", col0, e.col);
        end
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            exp_t e = q1.pop_front();
            chk("u1 validA", va1, e.va);
            chk("u1 dataA", da1, e.da);
            chk("u1 validB", vb1, e.vb);
            chk("u1 dataB", db1, e.db);
            chk("u1 collision", col1, e.col);
        end
    endtask

    function automatic vec_t mkv(input int ea, wa, ba, aa, xa, eb, wb, bb, ab, xb,
                                 input int va, xda0, xda1, vb, xdb0, xdb1, col);
        vec_t v;
        v.en_a = ea[0]; v.wr_a = wa[0]; v.be_a = ba[1:0]; v.addr_a = aa[3:0]; v.din_a = xa[15:0];
        v.en_b = eb[0]; v.wr_b = wb[0]; v.be_b = bb[1:0]; v.addr_b = ab[3:0]; v.din_b = xb[15:0];
        v.va  = va[0];  v.da0 = xda0[15:0]; v.da1 = xda1[15:0];
        v.vb  = vb[0];  v.db0 = xdb0[15:0]; v.db1 = xdb1[15:0];
        v.col = col[0];
        return v;
    endfunction

    // Drive one request cycle and queue its expected results per instance.
    task automatic step(input vec_t v);
        en_a = v.en_a; wr_a = v.wr_a; be_a = v.be_a; addr_a = v.addr_a; din_a = v.din_a;
        en_b = v.en_b; wr_b = v.wr_b; be_b = v.be_b; addr_b = v.addr_b; din_b = v.din_b;
        q0.push_back('{cyc + 1, v.va, v.da0, v.vb, v.db0, v.col});
        q1.push_back('{cyc + 2, v.va, v.da1, v.vb, v.db1, v.col});
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic chk_reset_state();
        chk("rst u0 validA", va0, 1'b0);
        chk("rst u0 validB", vb0, 1'b0);
        chk("rst u0 dataA", da0, 16'h0);
        chk("rst u0 dataB", db0, 16'h0);
        chk("rst u0 collision", col0, 1'b0);
        chk("rst u0 init_busy", busy0, 1'b1);
        chk("rst u1 validA", va1, 1'b0);
        chk("rst u1 validB", vb1, 1'b0);
        chk("rst u1 dataA", da1, 16'h0);
        chk("rst u1 dataB", db1, 16'h0);
        chk("rst u1 collision", col1, 1'b0);
        chk("rst u1 init_busy", busy1, 1'b1);
    endtask

    // Sixteen edges of clear with a port A read held on addr; none accepted.
    task automatic clear_phase(input int addr);
        for (int k = 1; k <= 16; k++) begin
            step(mkv(1, 0, 0, addr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            chk("u0 init_busy during clear", busy0, (k < 16));
            chk("u1 init_busy during clear", busy1, (k < 16));
        end
    endtask

    vec_t tbl[16];

    initial begin
        //            A: en wr be addr data      B: en wr be addr data    va da0     da1      vb db0     db1     col
        tbl[0]  = mkv(1, 1, 3, 1, 'h00A1,  0, 0, 0, 0, 0,       1, 'h0000, 'h00A1,  0, 'h0000, 'h0000, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0,       1, 0, 0, 1, 0,       0, 'h0000, 'h00A1,  1, 'h00A1, 'h00A1, 0);
        tbl[2]  = mkv(1, 1, 3, 3, 'h1234,  0, 0, 0, 0, 0,       1, 'h0000, 'h1234,  0, 'h00A1, 'h00A1, 0);
        tbl[3]  = mkv(1, 1, 2, 3, 'hABCD,  0, 0, 0, 0, 0,       1, 'h1234, 'hAB34,  0, 'h00A1, 'h00A1, 0);
        tbl[4]  = mkv(1, 0, 0, 3, 0,       0, 0, 0, 0, 0,       1, 'hAB34, 'hAB34,  0, 'h00A1, 'h00A1, 0);
        tbl[5]  = mkv(1, 1, 3, 6, 'hF6F6,  1, 1, 1, 6, 'h1717,  1, 'h0000, 'hF6F6,  1, 'h0000, 'hF6F6, 1);
        tbl[6]  = mkv(1, 0, 0, 6, 0,       1, 0, 0, 6, 0,       1, 'hF617, 'hF6F6,  1, 'hF617, 'hF6F6, 0);
        tbl[7]  = mkv(1, 1, 3, 2, 'h0022,  0, 0, 0, 0, 0,       1, 'h0000, 'h0022,  0, 'hF617, 'hF6F6, 0);
        tbl[8]  = mkv(1, 1, 3, 2, 'h0055,  1, 0, 0, 2, 0,       1, 'h0022, 'h0055,  1, 'h0022, 'h0022, 1);
        tbl[9]  = mkv(1, 0, 0, 1, 0,       1, 0, 0, 2, 0,       1, 'h00A1, 'h00A1,  1, 'h0055, 'h0055, 0);
        tbl[10] = mkv(1, 1, 0, 4, 'hBEEF,  0, 0, 0, 0, 0,       1, 'h0000, 'h0000,  0, 'h0055, 'h0055, 0);
        tbl[11] = mkv(1, 0, 0, 4, 0,       0, 0, 0, 0, 0,       1, 'h0000, 'h0000,  0, 'h0055, 'h0055, 0);
        tbl[12] = mkv(1, 1, 0, 5, 'hFFFF,  1, 1, 3, 5, 'h1111,  1, 'h0000, 'h1111,  1, 'h0000, 'h1111, 1);
        tbl[13] = mkv(1, 0, 0, 5, 0,       1, 1, 1, 7, 'h7777,  1, 'h1111, 'h1111,  1, 'h0000, 'h0077, 0);
        tbl[14] = mkv(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       0, 'h1111, 'h1111,  0, 'h0000, 'h0077, 0);
        tbl[15] = mkv(1, 0, 0, 7, 0,       1, 0, 0, 7, 0,       1, 'h0077, 'h0077,  1, 'h0077, 'h0077, 0);

        rst_n = 1'b0;
        en_a = 1'b0; wr_a = 1'b0; be_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; wr_b = 1'b0; be_b = '0; addr_b = '0; din_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();

        rst_n = 1'b1;
        clear_phase(0);

        // Whole array reads back as zero after the clear.
        for (int i = 0; i < 16; i++)
            step(mkv(1, 0, 0, i, 0, 1, 0, 0, 15 - i, 0, 1, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < 16; i++)
            step(tbl[i]);

        // Reset asserted mid-stream with reads in flight.
        step(mkv(1, 0, 0, 1, 0, 1, 0, 0, 6, 0, 1, 'h00A1, 'h00A1, 1, 'hF617, 'hF6F6, 0));
        en_a = 1'b1; wr_a = 1'b0; addr_a = 4'h3;
        en_b = 1'b1; wr_b = 1'b0; addr_b = 4'h3;
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        chk_reset_state();
        rst_n = 1'b1;
        clear_phase(3);

        // Cleared again from address 0: previously written words are zero.
        step(mkv(1, 0, 0, 1, 0, 1, 0, 0, 6, 0, 1, 0, 0, 1, 0, 0, 0));
        step(mkv(1, 0, 0, 3, 0, 1, 0, 0, 5, 0, 1, 0, 0, 1, 0, 0, 0));
        step(mkv(1, 0, 0, 5, 0, 1, 0, 0, 3, 0, 1, 0, 0, 1, 0, 0, 0));
        step(mkv(1, 0, 0, 6, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0));

        en_a = 1'b0; wr_a = 1'b0;
        en_b = 1'b0; wr_b = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            cyc++;
            check_due();
        end
        chk("scoreboard drained", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
